// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fulladder_half.sv
// 1-bit full adder cell built from two half adders.
module fulladder_half (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;
  logic g1;
  logic g2;

  assign p  = a ^ b;
  assign g1 = a & b;
  assign s  = p ^ ci;
  assign g2 = p & ci;
  assign co = g1 | g2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fulladder_half slice, LSB first, one bit per clock.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   ra_q, ra_d;
  logic [WIDTH-1:0]   rb_q, rb_d;
  logic [WIDTH-1:0]   rs_q, rs_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   s_d;
  logic               co_d;
  logic               busy_d;
  logic               done_d;
  logic               fa_s;
  logic               fa_co;

  fulladder_half u_fa (
    .a  (ra_q[0]),
    .b  (rb_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state and datapath update; s/co only move on the final shift edge.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rs_d    = rs_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s;
    co_d    = co;

    case (state_q)
      IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          carry_d = ci;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ra_d    = ra_q >> 1;
        rb_d    = rb_q >> 1;
        rs_d    = {fa_s, rs_q[WIDTH-1:1]};
        carry_d = fa_co;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          s_d     = {fa_s, rs_q[WIDTH-1:1]};
          co_d    = fa_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Synchronous reset clears every register and aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      rs_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s       <= '0;
      co      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rs_q    <= rs_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s       <= s_d;
      co      <= co_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule
